// File: rtl/deltaadc_pkg.sv
// Shared types and width helpers for the delta-ADC conversion sequencer.
// Defaults mirror the tt_um_DeltaADC core as taped out.
package deltaadc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StDiscard,
    StAccum,
    StOutput
  } seq_state_t;

  localparam int unsigned DefW         = 16;
  localparam int unsigned DefNavgLog2  = 2;
  localparam int unsigned DefRstCycles = 2;
  localparam int unsigned DefTimeout   = 65535;

  localparam int unsigned AccW  = DefW + DefNavgLog2;
  localparam int unsigned CntW  = DefNavgLog2 + 1;
  localparam int unsigned WdogW = $clog2(DefTimeout);

  function automatic int unsigned acc_width(int unsigned w, int unsigned navg_log2);
    return w + navg_log2;
  endfunction

  function automatic int unsigned cnt_width(int unsigned navg_log2);
    return navg_log2 + 1;
  endfunction

  function automatic int unsigned wdog_width(int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/deltaadc_if.sv
// Result handshake between the sequencer (master) and its consumer (slave).
interface deltaadc_if #(
  parameter int unsigned W = 16
);
  logic [W-1:0] res_data;
  logic         res_valid;
  logic         res_ready;

  modport master (output res_data, output res_valid, input res_ready);
  modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/deltaadc_watchdog.sv
// Strobe watchdog: counts enabled cycles and flags expiry at TIMEOUT_CYCLES-1.
module deltaadc_watchdog
  import deltaadc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeout
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned WdBits = wdog_width(TIMEOUT_CYCLES);
  localparam logic [WdBits-1:0] Limit = WdBits'(TIMEOUT_CYCLES - 1);

  logic [WdBits-1:0] cnt_q;

  assign expire_o = en_i & (cnt_q == Limit);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/deltaadc_seq.sv
// Conversion sequencer for the delta-modulation ADC core: primes the core, drops the
// first partial conversion, averages 2^NAVG_LOG2 samples and hands the mean out.
module deltaadc_seq
  import deltaadc_pkg::*;
#(
  parameter int unsigned W              = DefW,
  parameter int unsigned NAVG_LOG2      = DefNavgLog2,
  parameter int unsigned RST_CYCLES     = DefRstCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeout
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] cfg_period,
  output logic         busy,
  output logic         timeout_err,
  output logic         adc_reset,
  output logic [W-1:0] adc_period,
  input  logic [W-1:0] adc_on_count,
  input  logic         adc_valid_strb,
  deltaadc_if.master   res
);

  localparam int unsigned AccBits   = acc_width(W, NAVG_LOG2);
  localparam int unsigned CntBits   = cnt_width(NAVG_LOG2);
  localparam int unsigned PrimeBits = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [CntBits-1:0]   LastCnt   = CntBits'((1 << NAVG_LOG2) - 1);
  localparam logic [PrimeBits-1:0] LastPrime = PrimeBits'(RST_CYCLES - 1);

  seq_state_t           state_q;
  logic                 busy_q, terr_q, adc_reset_q, res_valid_q, strb_q;
  logic [W-1:0]         adc_period_q, res_data_q;
  logic [AccBits-1:0]   acc_q, acc_sum;
  logic [CntBits-1:0]   cnt_q;
  logic [PrimeBits-1:0] prime_q;
  logic                 strb_edge, wd_en, wd_expire;

  // One sample per strobe pulse regardless of how long the core holds it high.
  assign strb_edge = adc_valid_strb & ~strb_q;
  assign acc_sum   = acc_q + AccBits'(adc_on_count);
  assign wd_en     = (state_q == StDiscard) || (state_q == StAccum);

  deltaadc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (~wd_en | strb_edge),
    .en_i    (wd_en),
    .expire_o(wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
      adc_reset_q  <= 1'b1;
      adc_period_q <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      prime_q      <= '0;
      strb_q       <= 1'b0;
    end else begin
      strb_q <= adc_valid_strb;
      if (abort) begin
        state_q     <= StIdle;
        busy_q      <= 1'b0;
        adc_reset_q <= 1'b1;
        res_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && (cfg_period != '0)) begin
              state_q      <= StPrime;
              busy_q       <= 1'b1;
              adc_reset_q  <= 1'b1;
              adc_period_q <= cfg_period;
              terr_q       <= 1'b0;
              acc_q        <= '0;
              cnt_q        <= '0;
              prime_q      <= '0;
            end
          end
          StPrime: begin
            if (prime_q == LastPrime) begin
              state_q     <= StDiscard;
              adc_reset_q <= 1'b0;
            end else begin
              prime_q <= prime_q + 1'b1;
            end
          end
          StDiscard: begin
            if (strb_edge) begin
              state_q <= StAccum;
            end else if (wd_expire) begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              adc_reset_q <= 1'b1;
              terr_q      <= 1'b1;
            end
          end
          StAccum: begin
            if (strb_edge) begin
              acc_q <= acc_sum;
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == LastCnt) begin
                state_q     <= StOutput;
                adc_reset_q <= 1'b1;
                res_valid_q <= 1'b1;
                res_data_q  <= acc_sum[AccBits-1:NAVG_LOG2];
              end
            end else if (wd_expire) begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              adc_reset_q <= 1'b1;
              terr_q      <= 1'b1;
            end
          end
          StOutput: begin
            if (res.res_ready) begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              res_valid_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy          = busy_q;
  assign timeout_err   = terr_q;
  assign adc_reset     = adc_reset_q;
  assign adc_period    = adc_period_q;
  assign res.res_data  = res_data_q;
  assign res.res_valid = res_valid_q;

endmodule

// File: tb/tb_deltaadc_seq.sv
// Self-checking bench for deltaadc_seq: table vectors, randomized conversions against an
// arithmetic averaging model, and hand-written timeout/abort/reset sequences.
module tb_deltaadc_seq;

  localparam int unsigned W  = 16;
  localparam int unsigned NL = 2;
  localparam int unsigned RC = 2;
  localparam int unsigned TO = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] adc_on_count = '0;
  logic         adc_valid_strb = 1'b0;
  logic         busy, timeout_err, adc_reset;
  logic [W-1:0] adc_period;

  deltaadc_if #(.W(W)) rif ();

  always #5 clk = ~clk;

  deltaadc_seq #(
    .W             (W),
    .NAVG_LOG2     (NL),
    .RST_CYCLES    (RC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .cfg_period    (cfg_period),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .adc_reset     (adc_reset),
    .adc_period    (adc_period),
    .adc_on_count  (adc_on_count),
    .adc_valid_strb(adc_valid_strb),
    .res           (rif)
  );

  typedef struct packed {
    logic [W-1:0]      period;
    logic [4:0][W-1:0] s;       // s[0] is the discarded first conversion
    logic [7:0]        len;
    logic [7:0]        gap;
    logic [7:0]        rdly;
    logic [W-1:0]      exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int p, input int s0, input int s1, input int s2,
                              input int s3, input int s4, input int len, input int gap,
                              input int rdly, input int exp);
    vec_t v;
    v.period = W'(p);
    v.s[0] = W'(s0); v.s[1] = W'(s1); v.s[2] = W'(s2); v.s[3] = W'(s3); v.s[4] = W'(s4);
    v.len = 8'(len); v.gap = 8'(gap); v.rdly = 8'(rdly); v.exp = W'(exp);
    return v;
  endfunction

  // Mean of the kept samples, truncated.
  function automatic int model_avg(input vec_t v);
    int sum = 0;
    for (int i = 1; i <= (1 << NL); i++) sum += int'(v.s[i]);
    return sum / (1 << NL);
  endfunction

  // Value changes after the rising cycle so a level-sampling design picks up garbage.
  task automatic pulse(input logic [W-1:0] v, input int len, input int gap);
    adc_on_count   = v;
    adc_valid_strb = 1'b1;
    step();
    adc_on_count = ~v;
    repeat (len - 1) step();
    adc_valid_strb = 1'b0;
    repeat (gap) step();
  endtask

  task automatic do_start(input logic [W-1:0] period);
    cfg_period = period;
    start      = 1'b1;
    step();
    start      = 1'b0;
    cfg_period = W'($urandom);
    check("start_busy", busy, 1);
    check("start_period", adc_period, period);
    check("prime_rst_first", adc_reset, 1);
    repeat (RC - 1) begin
      step();
      check("prime_rst_held", adc_reset, 1);
    end
    step();
    check("discard_rst_low", adc_reset, 0);
  endtask

  task automatic run_conv(input vec_t v);
    logic [W-1:0] d0;
    int n;
    do_start(v.period);
    for (int i = 0; i < 4; i++) pulse(v.s[i], int'(v.len), int'(v.gap));
    check("no_early_valid", rif.res_valid, 0);
    adc_on_count   = v.s[4];
    adc_valid_strb = 1'b1;
    step();
    adc_on_count = ~v.s[4];
    check("valid_latency", rif.res_valid, 1);
    repeat (int'(v.len) - 1) step();
    adc_valid_strb = 1'b0;
    step();
    n = 0;
    while (!rif.res_valid && n < 20) begin
      step();
      n++;
    end
    check("valid_seen", rif.res_valid, 1);
    check("res_data", rif.res_data, v.exp);
    check("output_rst_high", adc_reset, 1);
    check("output_period", adc_period, v.period);
    d0 = rif.res_data;
    repeat (int'(v.rdly)) begin
      step();
      check("hold_valid", rif.res_valid, 1);
      check("hold_data", rif.res_data, d0);
    end
    rif.res_ready = 1'b1;
    step();
    rif.res_ready = 1'b0;
    check("xfer_valid_drop", rif.res_valid, 0);
    check("xfer_busy_drop", busy, 0);
  endtask

  vec_t vecs[4];
  vec_t rv;
  int   n;
  logic seen;

  initial begin
    rif.res_ready = 1'b0;
    vecs[0] = mk(200, 50, 100, 101, 102, 103, 1, 2, 0, 101);
    vecs[1] = mk(200, 50, 100, 101, 102, 103, 16, 3, 10, 101);
    vecs[2] = mk(37, 7, 65535, 65535, 65535, 65535, 3, 1, 2, 65535);
    vecs[3] = mk(1, 9, 0, 1, 2, 4, 2, 1, 1, 1);

    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_adc_reset", adc_reset, 1);
    check("rst_period", adc_period, 0);
    check("rst_res_valid", rif.res_valid, 0);
    check("rst_res_data", rif.res_data, 0);
    check("rst_terr", timeout_err, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) run_conv(vecs[i]);

    for (int k = 0; k < 6; k++) begin
      rv.period = W'($urandom_range(1, 65535));
      for (int i = 0; i < 5; i++) rv.s[i] = W'($urandom_range(0, 65535));
      rv.len  = 8'($urandom_range(1, 6));
      rv.gap  = 8'($urandom_range(1, 4));
      rv.rdly = 8'($urandom_range(0, 4));
      rv.exp  = W'(model_avg(rv));
      run_conv(rv);
    end

    // Watchdog: no strobes after PRIME.
    do_start(16'd5);
    n = 0;
    seen = 1'b0;
    while (!timeout_err && n < int'(TO) + 50) begin
      step();
      n++;
      if (rif.res_valid) seen = 1'b1;
    end
    check("timeout_cycles", n, TO);
    check("timeout_busy", busy, 0);
    check("timeout_rst_high", adc_reset, 1);
    check("timeout_no_result", seen, 0);

    // Zero period is ignored; start+abort is not accepted; neither touches timeout_err.
    cfg_period = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("zero_period_busy", busy, 0);
    check("zero_period_terr", timeout_err, 1);
    cfg_period = 16'd9;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_terr", timeout_err, 1);
    cfg_period = 16'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    check("terr_cleared", timeout_err, 0);
    check("terr_restart_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_prime_busy", busy, 0);

    // Abort coinciding with a strobe edge in ACCUM.
    do_start(16'd200);
    pulse(16'd50, 1, 2);
    pulse(16'd100, 1, 2);
    pulse(16'd101, 1, 2);
    adc_on_count   = 16'd500;
    adc_valid_strb = 1'b1;
    abort          = 1'b1;
    step();
    abort          = 1'b0;
    adc_valid_strb = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rst_high", adc_reset, 1);
    check("abort_no_valid", rif.res_valid, 0);
    check("abort_terr", timeout_err, 0);
    seen = 1'b0;
    repeat (10) begin
      step();
      if (rif.res_valid || busy) seen = 1'b1;
    end
    check("abort_stays_idle", seen, 0);
    run_conv(vecs[0]);

    // Asynchronous reset in the middle of ACCUM.
    do_start(16'd300);
    pulse(16'd1, 1, 1);
    pulse(16'd2, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rst_high", adc_reset, 1);
    check("arst_period", adc_period, 0);
    check("arst_res_data", rif.res_data, 0);
    check("arst_res_valid", rif.res_valid, 0);
    check("arst_terr", timeout_err, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    run_conv(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
